// File: rtl/mux_pkg.sv
// Shared types and constants for the scanning multiplexer and its dwell timer.
// No logic here; clog2 covers tools without a usable $clog2 in parameter context.
package mux_pkg;

  typedef enum logic [1:0] {
    MANUAL,
    SCAN,
    HOLD
  } state_t;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Free-running dwell counter: tick is high combinationally on the last count while en is set.
// clr (or reset) returns the count to 0; with en low the count is frozen. No backpressure.
module dwell_timer
  import mux_pkg::*;
#(
  parameter int DWELL = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = clog2(DWELL + 1);

  logic [CNT_W-1:0] r_cnt;

  assign tick = en && (r_cnt == CNT_W'(DWELL - 1));

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_cnt <= '0;
    end else if (tick) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mux_scan_nw.sv
// N-channel registered mux, manual select or round-robin auto-scan with hold.
// Latency 1 cycle from data_in/select to M; always accepts input, no backpressure.
module mux_scan_nw
  import mux_pkg::*;
#(
  parameter  int WIDTH    = 2,
  parameter  int CHANNELS = 4,
  parameter  int DWELL    = 50_000_000,
  localparam int SEL_W    = clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic [SEL_W-1:0]          select,
  input  logic                      mode,
  input  logic                      hold,
  output logic [WIDTH-1:0]          M,
  output logic [SEL_W-1:0]          active_ch,
  output logic                      step
);

  localparam int NPAD = 1 << SEL_W;

  state_t                  r_state;
  logic                    w_tick;
  logic                    w_en;
  logic                    w_clr;
  logic                    w_adv;
  logic [SEL_W-1:0]        w_next_ch;
  logic [NPAD*WIDTH-1:0]   w_pad;

  // Zero-padding to a power-of-2 channel count makes unused select codes read 0.
  assign w_pad = (NPAD*WIDTH)'(data_in);

  assign w_en  = (r_state == SCAN);
  assign w_clr = (r_state == MANUAL) || (mode == MODE_MANUAL);

  dwell_timer #(
    .DWELL (DWELL)
  ) u_dwell_timer (
    .clk   (clk),
    .reset (reset),
    .en    (w_en),
    .clr   (w_clr),
    .tick  (w_tick)
  );

  always_comb begin
    w_adv     = 1'b0;
    w_next_ch = active_ch;
    case (r_state)
      MANUAL: begin
        w_next_ch = (mode == MODE_SCAN) ? '0 : select;
      end
      SCAN: begin
        if (mode == MODE_MANUAL) begin
          w_next_ch = select;
        end else if (w_tick) begin
          w_adv     = 1'b1;
          w_next_ch = (active_ch == SEL_W'(CHANNELS - 1)) ? '0 : active_ch + 1'b1;
        end
      end
      default: begin
        if (mode == MODE_MANUAL) begin
          w_next_ch = select;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= MANUAL;
      M         <= '0;
      active_ch <= '0;
      step      <= 1'b0;
    end else begin
      active_ch <= w_next_ch;
      step      <= w_adv;
      M         <= w_pad[w_next_ch*WIDTH +: WIDTH];
      case (r_state)
        MANUAL: begin
          if (mode == MODE_SCAN) r_state <= SCAN;
        end
        SCAN: begin
          if (mode == MODE_MANUAL) r_state <= MANUAL;
          else if (hold)           r_state <= HOLD;
        end
        HOLD: begin
          if (mode == MODE_MANUAL) r_state <= MANUAL;
          else if (!hold)          r_state <= SCAN;
        end
        default: r_state <= MANUAL;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_nw.sv
// Directed bench: a 4x2-bit instance with DWELL=3 and a 3x2-bit instance with DWELL=1.
module tb_mux_scan_nw;

  logic       clk = 1'b0;
  logic       rst;

  logic [7:0] a_data;
  logic [1:0] a_sel;
  logic       a_mode, a_hold;
  logic [1:0] a_m, a_ch;
  logic       a_step;

  logic [5:0] b_data;
  logic [1:0] b_sel;
  logic       b_mode, b_hold;
  logic [1:0] b_m, b_ch;
  logic       b_step;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mux_scan_nw #(.WIDTH(2), .CHANNELS(4), .DWELL(3)) u_dut_a (
    .clk       (clk),
    .reset     (rst),
    .data_in   (a_data),
    .select    (a_sel),
    .mode      (a_mode),
    .hold      (a_hold),
    .M         (a_m),
    .active_ch (a_ch),
    .step      (a_step)
  );

  mux_scan_nw #(.WIDTH(2), .CHANNELS(3), .DWELL(1)) u_dut_b (
    .clk       (clk),
    .reset     (rst),
    .data_in   (b_data),
    .select    (b_sel),
    .mode      (b_mode),
    .hold      (b_hold),
    .M         (b_m),
    .active_ch (b_ch),
    .step      (b_step)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] b_exp_ch [5];
    logic       b_exp_st [5];
    logic [1:0] b_exp_m  [5];
    b_exp_ch = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
    b_exp_st = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    b_exp_m  = '{2'd3, 2'd1, 2'd2, 2'd3, 2'd1};

    // Reset with arbitrary, scan-requesting inputs
    rst = 1'b1;
    a_data = 8'h5A; a_sel = 2'd1; a_mode = 1'b1; a_hold = 1'b1;
    b_data = 6'h2D; b_sel = 2'd2; b_mode = 1'b1; b_hold = 1'b0;
    tick();
    tick();
    chk("rst_a_m", 8'(a_m), 8'd0);
    chk("rst_a_ch", 8'(a_ch), 8'd0);
    chk("rst_a_step", 8'(a_step), 8'd0);
    chk("rst_b_m", 8'(b_m), 8'd0);
    chk("rst_b_ch", 8'(b_ch), 8'd0);
    chk("rst_b_step", 8'(b_step), 8'd0);

    rst = 1'b0;
    a_data = 8'b11_10_01_00; a_mode = 1'b0; a_hold = 1'b0; a_sel = 2'd2;
    b_data = 6'b10_01_11;    b_mode = 1'b0; b_hold = 1'b0; b_sel = 2'd0;
    tick();
    chk("first_a_m", 8'(a_m), 8'd2);
    chk("first_a_ch", 8'(a_ch), 8'd2);

    // Manual sweep: output holds the old value until the edge
    for (int s = 0; s < 4; s++) begin
      a_sel = 2'(s);
      #1;
      chk("sweep_pre_m", 8'(a_m), (s == 0) ? 8'd2 : 8'(s - 1));
      tick();
      chk("sweep_m", 8'(a_m), 8'(s));
      chk("sweep_ch", 8'(a_ch), 8'(s));
      chk("sweep_step", 8'(a_step), 8'd0);
    end

    // Scan, DWELL=3: three cycles per channel, step on cycles 4,7,10,13,16
    a_mode = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      tick();
      chk("scan_ch", 8'(a_ch), 8'(((i - 1) / 3) % 4));
      chk("scan_m", 8'(a_m), 8'(((i - 1) / 3) % 4));
      chk("scan_step", 8'(a_step), (i > 1 && i % 3 == 1) ? 8'd1 : 8'd0);
    end

    // Hold on channel 1 with counter at 1; live data on channel 1 still tracked
    a_hold = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k == 3) a_data = 8'b11_10_11_00;
      tick();
      chk("hold_ch", 8'(a_ch), 8'd1);
      chk("hold_step", 8'(a_step), 8'd0);
      chk("hold_m", 8'(a_m), (k >= 3) ? 8'd3 : 8'd1);
    end
    a_data = 8'b11_10_01_00;
    a_hold = 1'b0;
    tick();
    chk("unhold1_ch", 8'(a_ch), 8'd1);
    chk("unhold1_step", 8'(a_step), 8'd0);
    tick();
    chk("unhold2_ch", 8'(a_ch), 8'd2);
    chk("unhold2_step", 8'(a_step), 8'd1);
    chk("unhold2_m", 8'(a_m), 8'd2);

    // mode=0 wins over hold
    a_hold = 1'b1; a_mode = 1'b0; a_sel = 2'd3;
    tick();
    chk("ovr_ch", 8'(a_ch), 8'd3);
    chk("ovr_m", 8'(a_m), 8'd3);
    chk("ovr_step", 8'(a_step), 8'd0);
    a_hold = 1'b0;

    // Reset mid-scan on channel 2, then a fresh full dwell on channel 0
    a_data = 8'b00_01_10_11;
    a_mode = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    chk("mid_ch", 8'(a_ch), 8'd2);
    chk("mid_m", 8'(a_m), 8'd1);
    rst = 1'b1;
    tick();
    chk("midrst_m", 8'(a_m), 8'd0);
    chk("midrst_ch", 8'(a_ch), 8'd0);
    chk("midrst_step", 8'(a_step), 8'd0);
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("restart_ch", 8'(a_ch), (i == 4) ? 8'd1 : 8'd0);
      chk("restart_step", 8'(a_step), (i == 4) ? 8'd1 : 8'd0);
      chk("restart_m", 8'(a_m), (i == 4) ? 8'd2 : 8'd3);
    end

    // Three channels: out-of-range select reads 0, scan wraps 2->0, DWELL=1 steps every cycle
    b_sel = 2'd3;
    tick();
    chk("b_oor_m", 8'(b_m), 8'd0);
    chk("b_oor_ch", 8'(b_ch), 8'd3);
    b_sel = 2'd2;
    tick();
    chk("b_sel2_m", 8'(b_m), 8'd2);
    b_mode = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("b_scan_ch", 8'(b_ch), 8'(b_exp_ch[i]));
      chk("b_scan_step", 8'(b_step), 8'(b_exp_st[i]));
      chk("b_scan_m", 8'(b_m), 8'(b_exp_m[i]));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mux_scan_nw.md
Name: mux_scan_nw

Overview:
Parametrised N-channel, W-bit registered multiplexer with two modes.
- Manual mode: the select input picks the channel.
- Auto-scan mode: an internal dwell timer steps through channels round-robin.

It feeds time-multiplexed board outputs (LED/7-seg display scanning, channel monitoring) on the DE-series lab designs. It generalises the 4-to-1 2-bit selector in width, channel count and mode.

Parameters:
WIDTH, 2, bits per channel (>=1)
CHANNELS, 4, number of input channels (2..16)
SEL_W, $clog2(CHANNELS), select/channel-index width (derived, not overridden)
DWELL, 50_000_000, clock cycles each channel is shown in scan mode (>=1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
data_in  in  CHANNELS*WIDTH  flattened inputs; channel k = data_in[k*WIDTH +: WIDTH]
select  in  SEL_W  manual channel index
mode  in  1  0 = manual, 1 = auto-scan
hold  in  1  scan mode only: freeze the dwell timer and the current channel
M  out  WIDTH  registered mux output
active_ch  out  SEL_W  channel index currently driving M
step  out  1  one-cycle pulse when the scan advances to a new channel

Behaviour:
- One clock and one synchronous reset: `clk`, rising edge; `reset`, active-high and synchronous. There are no asynchronous paths.
- Reset (takes priority over all inputs): state=MANUAL, M=0, active_ch=0, step=0, dwell counter=0.
- FSM states: MANUAL, SCAN, HOLD.
  - MANUAL -> SCAN when mode=1.
  - SCAN -> HOLD when mode=1 and hold=1.
  - HOLD -> SCAN when hold=0.
  - SCAN or HOLD -> MANUAL when mode=0 (mode=0 overrides hold).
- MANUAL state:
  - active_ch <= select.
  - M <= channel[select] one cycle after select/data change (latency 1).
  - If select >= CHANNELS (non-power-of-2 CHANNELS): M <= 0 and active_ch <= select.
  - Dwell counter is held at 0; step=0.
- Entering SCAN from MANUAL: on the first SCAN cycle, active_ch <= 0 and the counter clears to 0. The scan always restarts at channel 0.
- SCAN state:
  - The counter increments each cycle.
  - When counter == DWELL-1: counter <= 0, active_ch <= (active_ch == CHANNELS-1) ? 0 : active_ch+1, and step=1 for that cycle. Otherwise step=0.
  - Wrap-around from CHANNELS-1 to 0 applies even when CHANNELS is not a power of 2.
  - DWELL=1 means the channel advances every cycle and step stays high continuously.
- HOLD state: counter and active_ch are frozen; step=0. On return to SCAN, counting resumes from the frozen value (no restart).
- M in SCAN and HOLD = channel[active_ch], registered. M tracks live data_in changes on the held channel with 1-cycle latency.
- step is registered and asserted in the same cycle active_ch takes its new value.
- Counter width: $clog2(DWELL+1) bits. It never exceeds DWELL-1.
- Reset asserted mid-scan: on the next edge all state returns to reset values. The scan does not resume.

Decomposition:
- Shared package `mux_pkg`:
  - state enum {MANUAL, SCAN, HOLD};
  - mode constants MODE_MANUAL=1'b0, MODE_SCAN=1'b1;
  - a clog2 helper function for tools lacking $clog2.
- One sub-module: `dwell_timer`. Parameter DWELL; inputs clk, reset, en, clr; output tick. It is reused for display refresh elsewhere.
- Channel selection is an indexed part-select of data_in. No per-channel instances.

Test Plan:
1. Reset. Apply reset=1 for 2 cycles with arbitrary inputs -> M=0, active_ch=0, step=0. Drive W=2, C=4, data_in=8'b11_10_01_00, mode=0, select=2 -> next cycle M=2'b10, active_ch=2.
2. Manual sweep, latency check. Step select through 0..3 on consecutive cycles -> M = 00, 01, 10, 11, each lagging select by exactly 1 cycle. Step is never asserted.
3. Scan with DWELL=3. Set mode=1 -> active_ch sequence 0,0,0,1,1,1,2,2,2,3,3,3,0 with M following. Step pulses on cycles 4, 7, 10, 13 relative to mode rise; the last pulse shows the wrap 3->0.
4. Hold. Set hold=1 while active_ch=1 and counter=1 for 5 cycles -> active_ch stays 1, step=0. After hold=0, the advance to 2 occurs 2 cycles later.
5. Non-power-of-2 channels. Use C=3, data_in=6'b10_01_11. Manual select=3 -> M=0. In scan mode -> sequence 0,1,2,0 with no index 3.
6. Reset mid-scan. Assert reset for 1 cycle while active_ch=2, mode=1 held -> M=0, active_ch=0. The scan then restarts from channel 0 with a full DWELL dwell.
